// File: rtl/bitrev_feeder.sv
// Bit-reversal reorder buffer: natural-order complex samples in, bit-reversed
// order frames out. Two ping-pong banks let a frame be written while the
// previous one drains, so sustained 1-sample/cycle input never stalls.
module bitrev_feeder #(
  parameter int WR   = 10,
  parameter int WI   = 8,
  parameter int LOGN = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [WR-1:0] in_r,
  input  logic signed [WI-1:0] in_i,
  output logic                 out_valid,
  output logic                 out_start,
  output logic                 out_last,
  output logic signed [WR-1:0] out_r,
  output logic signed [WI-1:0] out_i
);

  localparam int N = 1 << LOGN;
  localparam int W = WR + WI;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  logic [W-1:0]    mem_q [2][N];
  logic [LOGN-1:0] wcnt_q;
  logic [LOGN-1:0] rcnt_q;
  logic            wsel_q;
  logic            rsel_q;
  logic [1:0]      full_q;
  logic [1:0]      full_d;
  state_t          state_q;

  logic            accept;
  logic            wr_done;
  logic            rd_fire;
  logic            rd_done;
  logic [LOGN-1:0] raddr;
  logic [W-1:0]    rd_word;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < unsigned'(LOGN); b++) begin
      r[b] = a[LOGN-1-b];
    end
    return r;
  endfunction

  assign in_ready = ~full_q[wsel_q];
  assign accept   = in_valid & in_ready;
  assign wr_done  = accept && (wcnt_q == '1);
  // The reader consumes a word on every edge its bank is full: in STREAM this
  // always holds, and in IDLE it lets the first word leave on the same edge
  // the FSM leaves IDLE, which keeps the frame latency at one edge.
  assign rd_fire  = (state_q == STREAM) || full_q[rsel_q];
  assign rd_done  = rd_fire && (rcnt_q == '1);
  assign raddr    = bitrev(rcnt_q);
  assign rd_word  = mem_q[rsel_q][raddr];

  // Full flags: the write side sets its bank and the read side clears its
  // bank; the two banks always differ, so both updates land on one edge.
  always_comb begin
    full_d = full_q;
    if (wr_done) full_d[wsel_q] = 1'b1;
    if (rd_done) full_d[rsel_q] = 1'b0;
  end

  // Sample storage, written in natural order; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wsel_q][wcnt_q] <= {in_r, in_i};
  end

  // Write side: address counter, bank select and full flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_q <= '0;
      wsel_q <= 1'b0;
      full_q <= '0;
    end else begin
      full_q <= full_d;
      if (accept) begin
        wcnt_q <= wcnt_q + LOGN'(1);
        if (wr_done) wsel_q <= ~wsel_q;
      end
    end
  end

  // Reader FSM with registered output samples and frame markers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rcnt_q    <= '0;
      rsel_q    <= 1'b0;
      out_valid <= 1'b0;
      out_start <= 1'b0;
      out_last  <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
    end else begin
      out_valid <= 1'b0;
      out_start <= 1'b0;
      out_last  <= 1'b0;
      if (rd_fire) begin
        out_valid <= 1'b1;
        out_start <= (rcnt_q == '0);
        out_last  <= (rcnt_q == '1);
        out_r     <= rd_word[W-1:WI];
        out_i     <= rd_word[WI-1:0];
        rcnt_q    <= rcnt_q + LOGN'(1);
      end
      if (rd_done) rsel_q <= ~rsel_q;
      case (state_q)
        IDLE: begin
          if (rd_done)      state_q <= full_q[~rsel_q] ? STREAM : IDLE;
          else if (rd_fire) state_q <= STREAM;
        end
        STREAM: begin
          if (rd_done) state_q <= full_q[~rsel_q] ? STREAM : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitrev_feeder.sv
// Bench for bitrev_feeder: frame-level reference model predicting every output
// cycle and in_ready, plus literal checks on captured output sequences.
module tb_bitrev_feeder;

  localparam int WR   = 10;
  localparam int WI   = 8;
  localparam int LOGN = 5;
  localparam int N    = 1 << LOGN;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [WR-1:0] in_r = '0;
  logic signed [WI-1:0] in_i = '0;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_start;
  logic                 out_last;
  logic signed [WR-1:0] out_r;
  logic signed [WI-1:0] out_i;

  always #5 clk = ~clk;

  bitrev_feeder #(.WR(WR), .WI(WI), .LOGN(LOGN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_i(in_i), .out_valid(out_valid), .out_start(out_start),
    .out_last(out_last), .out_r(out_r), .out_i(out_i)
  );

  int n_chk = 0;
  int n_pass = 0;
  int edge_n = 0;

  // Model state: partial frame, completed-frame timing, expected outputs by cycle.
  int part_r[$];
  int part_i[$];
  int fr_c[$];
  int fr_l[$];
  int busy_until = 0;
  int exp_r[int];
  int exp_i[int];
  int exp_s[int];
  int exp_l[int];

  // Captured valid outputs for literal checks.
  int got_r[$];
  int got_i[$];
  int got_s[$];
  int got_l[$];

  function automatic void chk(string name, int act, int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, edge_n - 1, act, expv);
  endfunction

  function automatic int brev(int k);
    int r = 0;
    for (int b = 0; b < LOGN; b++) r = (r << 1) | ((k >> b) & 1);
    return r;
  endfunction

  // Writes are possible unless two frames are buffered and not yet fully drained.
  function automatic int model_ready(int t);
    int busy = 0;
    foreach (fr_c[j]) if (fr_c[j] <= t && fr_l[j] > t) busy++;
    return (busy < 2) ? 1 : 0;
  endfunction

  // Reference model: on each edge, absorb accepted samples and schedule whole frames.
  always @(posedge clk) begin : model
    int e;
    int start;
    e = edge_n;
    if (!rst) begin
      part_r.delete(); part_i.delete();
      fr_c.delete(); fr_l.delete();
      exp_r.delete(); exp_i.delete(); exp_s.delete(); exp_l.delete();
      busy_until = 0;
    end else if (in_valid && model_ready(e - 1) == 1) begin
      part_r.push_back(int'(in_r));
      part_i.push_back(int'(in_i));
      if (part_r.size() == N) begin
        start = (e + 1 > busy_until) ? e + 1 : busy_until;
        for (int k = 0; k < N; k++) begin
          exp_r[start + k] = part_r[brev(k)];
          exp_i[start + k] = part_i[brev(k)];
          exp_s[start + k] = (k == 0) ? 1 : 0;
          exp_l[start + k] = (k == N - 1) ? 1 : 0;
        end
        fr_c.push_back(e);
        fr_l.push_back(start + N - 1);
        busy_until = start + N;
        part_r.delete(); part_i.delete();
      end
    end
    edge_n = e + 1;
  end

  int hold_r = 0;
  int hold_i = 0;

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin : compare
    int t;
    t = edge_n - 1;
    if (!rst) begin
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_start", int'(out_start), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_out_r", int'(out_r), 0);
      chk("rst_out_i", int'(out_i), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      hold_r = 0;
      hold_i = 0;
    end else begin
      if (exp_r.exists(t)) begin
        chk("out_valid", int'(out_valid), 1);
        chk("out_r", int'(out_r), exp_r[t]);
        chk("out_i", int'(out_i), exp_i[t]);
        chk("out_start", int'(out_start), exp_s[t]);
        chk("out_last", int'(out_last), exp_l[t]);
        hold_r = exp_r[t];
        hold_i = exp_i[t];
      end else begin
        chk("out_valid_idle", int'(out_valid), 0);
        chk("out_start_idle", int'(out_start), 0);
        chk("out_last_idle", int'(out_last), 0);
        chk("out_r_hold", int'(out_r), hold_r);
        chk("out_i_hold", int'(out_i), hold_i);
      end
      chk("in_ready", int'(in_ready), model_ready(t));
      if (out_valid) begin
        got_r.push_back(int'(out_r));
        got_i.push_back(int'(out_i));
        got_s.push_back(int'(out_start));
        got_l.push_back(int'(out_last));
      end
    end
  end

  task automatic send(input int v, input int r, input int i);
    @(posedge clk);
    #1;
    in_valid = v[0];
    in_r     = r[WR-1:0];
    in_i     = i[WI-1:0];
  endtask

  task automatic idle(input int n);
    repeat (n) send(0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int base;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Ramp 0..31
    base = got_r.size();
    for (int v = 0; v < N; v++) send(1, v, v);
    idle(40);
    chk("ramp_count", got_r.size() - base, 32);
    chk("ramp_o0", got_r[base], 0);
    chk("ramp_o1", got_r[base + 1], 16);
    chk("ramp_o2", got_r[base + 2], 8);
    chk("ramp_o3", got_r[base + 3], 24);
    chk("ramp_o8", got_r[base + 8], 2);
    chk("ramp_o31", got_r[base + 31], 31);
    chk("ramp_i1", got_i[base + 1], 16);
    chk("ramp_start", got_s[base], 1);
    chk("ramp_last", got_l[base + 31], 1);

    // Back-to-back 0..63
    base = got_r.size();
    for (int v = 0; v < 2 * N; v++) send(1, v, v);
    idle(80);
    chk("b2b_count", got_r.size() - base, 64);
    chk("b2b_o32", got_r[base + 32], 32);
    chk("b2b_o33", got_r[base + 33], 48);
    chk("b2b_o34", got_r[base + 34], 40);
    chk("b2b_o35", got_r[base + 35], 56);
    chk("b2b_o63", got_r[base + 63], 63);
    chk("b2b_start2", got_s[base + 32], 1);

    // Gapped ramp
    base = got_r.size();
    for (int v = 0; v < N; v++) begin
      send(1, v, v);
      send(0, 0, 0);
    end
    idle(40);
    chk("gap_count", got_r.size() - base, 32);
    chk("gap_o1", got_r[base + 1], 16);
    chk("gap_o31", got_r[base + 31], 31);

    // Extremes
    base = got_r.size();
    send(1, -512, -128);
    send(1, 511, 127);
    for (int v = 2; v < N; v++) send(1, 0, 0);
    idle(40);
    chk("ext_r0", got_r[base], -512);
    chk("ext_i0", got_i[base], -128);
    chk("ext_r16", got_r[base + 16], 511);
    chk("ext_i16", got_i[base + 16], 127);

    // Reset during a partial write frame
    for (int v = 0; v < 20; v++) send(1, 500 + v, v);
    do_reset();
    base = got_r.size();
    for (int v = 100; v < 100 + N; v++) send(1, v, v);
    idle(40);
    chk("rstw_count", got_r.size() - base, 32);
    chk("rstw_o0", got_r[base], 100);
    chk("rstw_o1", got_r[base + 1], 116);
    chk("rstw_o2", got_r[base + 2], 108);

    // Reset while a frame is draining
    for (int v = 0; v < N; v++) send(1, v + 200, v);
    idle(5);
    do_reset();
    idle(40);

    // Three sustained frames: reader busy while the next frame arrives
    base = got_r.size();
    for (int v = 0; v < 3 * N; v++) send(1, v, v + 7);
    idle(100);
    chk("ovf_count", got_r.size() - base, 96);
    chk("ovf_o64", got_r[base + 64], 64);
    chk("ovf_o65", got_r[base + 65], 80);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      send(($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom), int'($urandom));
    end
    idle(80);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bitrev_feeder.md
BITREV_FEEDER -- requirements
Module: bitrev_feeder

Interface
REQ-001 SHALL have parameter WR, default 10, real-part sample width in bits (signed).
REQ-002 SHALL have parameter WI, default 8, imaginary-part sample width in bits (signed).
REQ-003 SHALL have parameter LOGN, default 5, log2 of frame length; N = 2^LOGN = 32 samples.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  input sample present this cycle.
REQ-007 SHALL have port in_ready  output  1  block can accept a sample this cycle.
REQ-008 SHALL have port in_r  input  WR  signed real part, natural-order index.
REQ-009 SHALL have port in_i  input  WI  signed imaginary part, natural-order index.
REQ-010 SHALL have port out_valid  output  1  output sample valid; downstream has no backpressure.
REQ-011 SHALL have port out_start  output  1  one-cycle pulse coincident with first sample of each output frame.
REQ-012 SHALL have port out_last  output  1  one-cycle pulse coincident with sample N-1 of each output frame.
REQ-013 SHALL have port out_r  output  WR  signed real part, bit-reversed order.
REQ-014 SHALL have port out_i  output  WI  signed imaginary part, bit-reversed order.

Function
REQ-015 SHALL contain two banks of N entries, each entry WR+WI bits, with per-bank full flag, write-bank select wsel, and read-bank select rsel.
REQ-016 SHALL accept a sample on a rising edge iff in_valid=1 and in_ready=1, writing it to bank wsel at address wcnt, then wcnt increments modulo N.
REQ-017 SHALL drive in_ready = NOT full[wsel] combinationally; samples offered while in_ready=0 are not written.
REQ-018 On the accept with wcnt=N-1, SHALL set full[wsel], toggle wsel, and wrap wcnt to 0.
REQ-019 SHALL implement reader FSM with states IDLE and STREAM, plus read counter rcnt (LOGN bits).
REQ-020 IDLE: if full[rsel]=1, SHALL enter STREAM with rcnt=0; otherwise remain IDLE with out_valid=0.
REQ-021 STREAM: each cycle SHALL register bank rsel entry at address bitrev(rcnt) onto out_r/out_i with out_valid=1, then increment rcnt.
REQ-022 out_start SHALL be 1 on the output cycle for rcnt=0; out_last SHALL be 1 on the output cycle for rcnt=N-1; both otherwise 0.
REQ-023 After the rcnt=N-1 read, SHALL clear full[rsel] and toggle rsel; if the other bank is full on that edge, SHALL stay in STREAM with rcnt=0 (back-to-back frames, no gap); else SHALL return to IDLE.
REQ-024 Latency: first out_valid of a frame SHALL appear on the rising edge following the edge on which that frame's full flag was set (IDLE case).
REQ-025 Sample values SHALL pass unmodified (no rounding, saturation, or sign change); out_r/out_i SHALL hold last value when out_valid=0.
REQ-026 Setting full on one bank and clearing full on the other in the same edge SHALL both take effect.
REQ-027 With sustained 1-sample/cycle input, SHALL produce continuous output with in_ready never deasserted.
REQ-028 Gaps in in_valid SHALL only delay frame completion; partial frames are never emitted.

Reset
REQ-029 On rst=0, SHALL immediately set wcnt=0, rcnt=0, wsel=0, rsel=0, both full flags=0, FSM=IDLE, out_valid=0, out_start=0, out_last=0, out_r=0, out_i=0.
REQ-030 Reset mid-frame (on write or read side) SHALL discard all buffered and partially written samples; bank memory contents need not be cleared.
REQ-031 After rst returns to 1, in_ready SHALL be 1 in the first cycle.

Verification
REQ-032 Ramp: feed in_r=in_i=0..31 continuously -> out_r sequence 0,16,8,24,4,20,12,28,2,...,31; out_i identical; out_start on first, out_last on 32nd output.
REQ-033 Back-to-back: feed 64 consecutive samples 0..63 -> 64 contiguous out_valid cycles; second frame 32,48,40,56,...,63; out_start at outputs 1 and 33.
REQ-034 Gapped input: ramp 0..31 with in_valid=0 every other cycle -> no out_valid until the edge after sample 31 accepted, then same 32-value sequence as REQ-032.
REQ-035 Extremes: index 0 = (-512,-128), index 1 = (511,127), others 0 -> output position 0 = (-512,-128), output position 16 = (511,127), exact sign preserved.
REQ-036 Reset mid-frame: accept 20 samples, pulse rst=0, then feed ramp 100..131 -> no output before reset recovery frame; first output frame starts with 100,116,108.
REQ-037 Overflow hold: complete two frames while forcing reader busy (feed second frame during first drain at full rate) -> in_ready stays 1, no sample lost, outputs match golden bit-reversed order.
